// File: rtl/toggle_decoder_pkg.sv
// Shared definitions for the toggle decoder: FSM state encoding, default
// parameter values and a saturating increment helper.
// No ports (package).
package tgl_dec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_INT_W   = 16;
  localparam int DEF_TIMEOUT = 1000;

  // Increment v, holding at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/toggle_decoder_if.sv
// Event-line bus between a toggle source and the toggle decoder.
//   tgl_in, clr                 : driven by the master (source side)
//   evt_pulse, evt_count,
//   interval, interval_valid,
//   stall                       : driven by the slave (decoder)
interface toggle_decoder_if
  import tgl_dec_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int INT_W = DEF_INT_W
);
  logic             tgl_in;
  logic             clr;
  logic             evt_pulse;
  logic [CNT_W-1:0] evt_count;
  logic [INT_W-1:0] interval;
  logic             interval_valid;
  logic             stall;

  modport master (
    output tgl_in, clr,
    input  evt_pulse, evt_count, interval, interval_valid, stall
  );

  modport slave (
    input  tgl_in, clr,
    output evt_pulse, evt_count, interval, interval_valid, stall
  );
endinterface

// File: rtl/toggle_decoder_edge_det.sv
// Transition detector for the toggle line.
// Optional macro TGL_DEC_GLITCH_FILTER_EN adds a 2-sample level filter
// (one extra cycle of latency, single-cycle glitches ignored).
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset (preloads the reference level)
//   tgl_in in  toggle line, synchronous to clk
//   trans  out transition strobe, decoded from registered state; the top
//              registers it so the pulse lands on the same edge
module tgl_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_in,
  output logic trans
);

`ifdef TGL_DEC_GLITCH_FILTER_EN
  logic tgl_s;  // previous raw sample
  logic tgl_q;  // accepted level

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgl_s <= tgl_in;
      tgl_q <= tgl_in;
    end else begin
      tgl_s <= tgl_in;
      // a level is accepted once two consecutive samples agree
      if (tgl_in == tgl_s) tgl_q <= tgl_s;
    end
  end

  assign trans = (tgl_in == tgl_s) && (tgl_s != tgl_q);
`else
  logic tgl_q;

  // reset preload and normal update are the same: track the line so a
  // high level at reset release is not seen as an event
  always_ff @(posedge clk) begin
    if (!rst_n) tgl_q <= tgl_in;
    else        tgl_q <= tgl_in;
  end

  assign trans = tgl_in ^ tgl_q;
`endif

endmodule

// File: rtl/toggle_decoder.sv
// Toggle-encoded event decoder: one pulse per line transition, running event
// count, interval between events and stall detection.
// Optional macro TGL_DEC_GLITCH_FILTER_EN (handled in tgl_edge_det).
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  synchronous active-low reset
//   bus   slave modport of toggle_decoder_if (tgl_in/clr in, results out)
module toggle_decoder
  import tgl_dec_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int INT_W   = DEF_INT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  toggle_decoder_if.slave  bus
);

  localparam logic [INT_W-1:0] TIMEOUT_V = INT_W'(TIMEOUT);

  state_t           state;
  logic             trans;
  logic [INT_W-1:0] int_cnt;
  logic [INT_W-1:0] int_nxt;
  logic             evt_pulse;
  logic [CNT_W-1:0] evt_count;
  logic [INT_W-1:0] interval;
  logic             interval_valid;
  logic             stall;

  tgl_edge_det u_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .tgl_in (bus.tgl_in),
    .trans  (trans)
  );

  assign int_nxt = INT_W'(sat_inc(32'(int_cnt), unsigned'(INT_W)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      int_cnt        <= '0;
      evt_pulse      <= 1'b0;
      evt_count      <= '0;
      interval       <= '0;
      interval_valid <= 1'b0;
      stall          <= 1'b0;
    end else begin
      evt_pulse      <= 1'b0;
      interval_valid <= 1'b0;
      if (bus.clr) begin
        // a same-cycle transition is swallowed; interval is kept on purpose
        state     <= IDLE;
        int_cnt   <= '0;
        evt_count <= '0;
        stall     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trans) begin
              evt_pulse <= 1'b1;
              evt_count <= evt_count + 1'b1;
              int_cnt   <= '0;
              state     <= ARMED;
            end
          end
          ARMED: begin
            if (trans) begin
              evt_pulse      <= 1'b1;
              evt_count      <= evt_count + 1'b1;
              interval       <= int_nxt;
              interval_valid <= 1'b1;
              int_cnt        <= '0;
            end else begin
              int_cnt <= int_nxt;
              if (int_nxt == TIMEOUT_V) begin
                stall <= 1'b1;
                state <= STALLED;
              end
            end
          end
          STALLED: begin
            if (trans) begin
              evt_pulse <= 1'b1;
              evt_count <= evt_count + 1'b1;
              stall     <= 1'b0;
              int_cnt   <= '0;
              state     <= ARMED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.evt_pulse      = evt_pulse;
  assign bus.evt_count      = evt_count;
  assign bus.interval       = interval;
  assign bus.interval_valid = interval_valid;
  assign bus.stall          = stall;

endmodule

// File: tb/tb_toggle_decoder.sv
module tb_toggle_decoder;
  import tgl_dec_pkg::*;

  localparam int CNT_W   = 4;
  localparam int INT_W   = 16;
  localparam int TIMEOUT = 10;

  typedef struct packed {
    logic             pulse;
    logic [CNT_W-1:0] count;
    logic             iv;
    logic [INT_W-1:0] interval;
    logic             stall;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  toggle_decoder_if #(.CNT_W(CNT_W), .INT_W(INT_W)) bus ();

  toggle_decoder #(.CNT_W(CNT_W), .INT_W(INT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t             sb[$];
  obs_t             e_obs;
  obs_t             a_obs;
  int               total = 0;
  int               bad = 0;
  logic             tgl = 1'b1;
  logic [CNT_W-1:0] e_cnt = '0;
  logic [INT_W-1:0] e_int = '0;

  function automatic obs_t sample();
    return '{bus.evt_pulse, bus.evt_count, bus.interval_valid, bus.interval, bus.stall};
  endfunction

  task automatic tick(input logic t, input logic c);
    bus.tgl_in = t;
    bus.clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tgl   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{1'b0, '0, 1'b0, '0, 1'b0});
      tick(tgl, 1'b0);
      e_obs = sb.pop_front(); a_obs = sample(); total++;
      if (a_obs !== e_obs) begin bad++; $display("FAIL reset cyc%0d got=%h exp=%h", i, a_obs, e_obs); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, '0, 1'b0, '0, 1'b0});
      tick(tgl, 1'b0);
      e_obs = sb.pop_front(); a_obs = sample(); total++;
      if (a_obs !== e_obs) begin bad++; $display("FAIL reset_release cyc%0d got=%h exp=%h", i, a_obs, e_obs); end
    end
    e_cnt = '0;
    e_int = '0;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      tgl = ~tgl;
      e_cnt = e_cnt + 1'b1;
      if (i > 1) e_int = 16'd1;
      sb.push_back('{1'b1, e_cnt, (i > 1), e_int, 1'b0});
      tick(tgl, 1'b0);
      e_obs = sb.pop_front(); a_obs = sample(); total++;
      if (a_obs !== e_obs) begin bad++; $display("FAIL back_to_back ev%0d got=%h exp=%h", i, a_obs, e_obs); end
    end
    sb.push_back('{1'b0, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL back_to_back_idle got=%h exp=%h", a_obs, e_obs); end
  endtask

  task automatic test_interval();
    int gaps[5] = '{2, 2, 2, 5, 5};
    e_cnt = '0;
    sb.push_back('{1'b0, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b1);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL interval_clr got=%h exp=%h", a_obs, e_obs); end
    tgl = ~tgl;
    e_cnt = e_cnt + 1'b1;
    sb.push_back('{1'b1, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL interval_first got=%h exp=%h", a_obs, e_obs); end
    foreach (gaps[g]) begin
      for (int j = 1; j <= gaps[g]; j++) begin
        if (j == gaps[g]) begin
          tgl = ~tgl;
          e_cnt = e_cnt + 1'b1;
          e_int = INT_W'(gaps[g]);
          sb.push_back('{1'b1, e_cnt, 1'b1, e_int, 1'b0});
        end else begin
          sb.push_back('{1'b0, e_cnt, 1'b0, e_int, 1'b0});
        end
        tick(tgl, 1'b0);
        e_obs = sb.pop_front(); a_obs = sample(); total++;
        if (a_obs !== e_obs) begin bad++; $display("FAIL interval gap%0d j%0d got=%h exp=%h", gaps[g], j, a_obs, e_obs); end
      end
    end
  endtask

  task automatic test_stall();
    e_cnt = '0;
    tick(tgl, 1'b1);
    tgl = ~tgl;
    e_cnt = e_cnt + 1'b1;
    sb.push_back('{1'b1, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL stall_arm got=%h exp=%h", a_obs, e_obs); end
    for (int j = 1; j <= 12; j++) begin
      sb.push_back('{1'b0, e_cnt, 1'b0, e_int, (j >= TIMEOUT)});
      tick(tgl, 1'b0);
      e_obs = sb.pop_front(); a_obs = sample(); total++;
      if (a_obs !== e_obs) begin bad++; $display("FAIL stall_wait j%0d got=%h exp=%h", j, a_obs, e_obs); end
    end
    tgl = ~tgl;
    e_cnt = e_cnt + 1'b1;
    sb.push_back('{1'b1, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL stall_exit got=%h exp=%h", a_obs, e_obs); end
    tgl = ~tgl;
    e_cnt = e_cnt + 1'b1;
    e_int = 16'd1;
    sb.push_back('{1'b1, e_cnt, 1'b1, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL stall_rearm got=%h exp=%h", a_obs, e_obs); end
  endtask

  task automatic test_clr_toggle();
    e_cnt = '0;
    tick(tgl, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tgl = ~tgl;
      e_cnt = e_cnt + 1'b1;
      if (i > 1) e_int = 16'd1;
      sb.push_back('{1'b1, e_cnt, (i > 1), e_int, 1'b0});
      tick(tgl, 1'b0);
      e_obs = sb.pop_front(); a_obs = sample(); total++;
      if (a_obs !== e_obs) begin bad++; $display("FAIL clr_pre ev%0d got=%h exp=%h", i, a_obs, e_obs); end
    end
    tgl = ~tgl;
    e_cnt = '0;
    sb.push_back('{1'b0, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b1);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL clr_same_cycle got=%h exp=%h", a_obs, e_obs); end
    sb.push_back('{1'b0, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL clr_consumed got=%h exp=%h", a_obs, e_obs); end
    tgl = ~tgl;
    e_cnt = e_cnt + 1'b1;
    sb.push_back('{1'b1, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL clr_next got=%h exp=%h", a_obs, e_obs); end
  endtask

  task automatic test_wrap();
    e_cnt = '0;
    tick(tgl, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      tgl = ~tgl;
      e_cnt = e_cnt + 1'b1;
      if (i > 1) e_int = 16'd1;
      sb.push_back('{1'b1, e_cnt, (i > 1), e_int, 1'b0});
      tick(tgl, 1'b0);
      e_obs = sb.pop_front(); a_obs = sample(); total++;
      if (a_obs !== e_obs) begin bad++; $display("FAIL wrap ev%0d got=%h exp=%h", i, a_obs, e_obs); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) tick(~tgl, 1'b0) ;
    tgl = ~tgl;
    tgl = ~tgl;
    rst_n = 1'b0;
    tgl = ~tgl;
    sb.push_back('{1'b0, '0, 1'b0, '0, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL reset_mid got=%h exp=%h", a_obs, e_obs); end
    rst_n = 1'b1;
    e_cnt = '0;
    e_int = '0;
    sb.push_back('{1'b0, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL reset_mid_release got=%h exp=%h", a_obs, e_obs); end
    tgl = ~tgl;
    e_cnt = e_cnt + 1'b1;
    sb.push_back('{1'b1, e_cnt, 1'b0, e_int, 1'b0});
    tick(tgl, 1'b0);
    e_obs = sb.pop_front(); a_obs = sample(); total++;
    if (a_obs !== e_obs) begin bad++; $display("FAIL reset_mid_next got=%h exp=%h", a_obs, e_obs); end
  endtask

  task automatic test_glitch();
    // line levels per cycle after clr, and whether a pulse is expected
    logic seq_lvl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic seq_pls[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    e_cnt = '0;
    tick(tgl, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tgl = seq_lvl[i];
      if (seq_pls[i]) e_cnt = e_cnt + 1'b1;
      if (i == 6) e_int = 16'd5;
      sb.push_back('{seq_pls[i], e_cnt, (i == 6), e_int, 1'b0});
      tick(tgl, 1'b0);
      e_obs = sb.pop_front(); a_obs = sample(); total++;
      if (a_obs !== e_obs) begin bad++; $display("FAIL glitch cyc%0d got=%h exp=%h", i, a_obs, e_obs); end
    end
  endtask

  initial begin
    bus.tgl_in = 1'b1;
    bus.clr    = 1'b0;
    test_reset();
`ifdef TGL_DEC_GLITCH_FILTER_EN
    test_glitch();
`else
    test_back_to_back();
    test_interval();
    test_stall();
    test_clr_toggle();
    test_wrap();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
